// File: rtl/vga_sprite_line_fetcher_if.sv
// Video-port bus between the sprite line fetcher (master) and the 4096x16 sprite RAM (slave).
interface vga_sprite_line_fetcher_if;
  logic [11:0] mem_address;
  logic        mem_chipselect;
  logic        mem_write;
  logic [1:0]  mem_byteenable;
  logic [15:0] mem_readdata;

  modport master (
    output mem_address, mem_chipselect, mem_write, mem_byteenable,
    input  mem_readdata
  );

  modport slave (
    input  mem_address, mem_chipselect, mem_write, mem_byteenable,
    output mem_readdata
  );
endinterface

// File: rtl/vga_sprite_line_fetcher.sv
// Sprite line fetcher: loads one RGB565 sprite row into a line buffer each line, then serves pixels.
// Optional feature macro: SPRITE_HFLIP_EN (horizontal mirror on lookup).
module vga_sprite_line_fetcher #(
  parameter int          SPRITE_W    = 32,
  parameter int          SPRITE_H    = 32,
  parameter logic [15:0] TRANSPARENT = 16'hF81F
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        i_line_start,
  input  logic [9:0]  i_line_y,
  input  logic        i_sprite_en,
  input  logic [1:0]  i_sprite_idx,
  input  logic [9:0]  i_sprite_x,
  input  logic [9:0]  i_sprite_y,
  input  logic        i_sprite_hflip,
  input  logic [9:0]  i_pixel_x,
  output logic [15:0] o_pixel_rgb,
  output logic        o_pixel_opaque,
  output logic        o_fetch_busy,
  vga_sprite_line_fetcher_if.master mem
);

  localparam int CW = $clog2(SPRITE_W);
  localparam int RW = $clog2(SPRITE_H);
  localparam logic [CW-1:0] LAST_COL = CW'(SPRITE_W - 1);

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN} state_t;

  state_t        r_state, w_state_nxt;
  logic [CW-1:0] r_col;
  logic [RW-1:0] r_row;
  logic [1:0]    r_idx;
  logic [9:0]    r_sx;
  logic          r_line_valid;
  logic [11:0]   r_addr;
  logic [15:0]   r_pix_rgb;
  logic          r_pix_opaque;
  logic [15:0]   r_buf [SPRITE_W];

  logic          w_busy, w_cs, w_hit, w_in, w_opaque, w_cap_en;
  logic [9:0]    w_row, w_col;
  logic [CW-1:0] w_cap, w_ridx;
  logic [15:0]   w_c;

  assign w_row = i_line_y - i_sprite_y;
  assign w_hit = i_sprite_en && (w_row < 10'(SPRITE_H));

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= IDLE;
    else          r_state <= w_state_nxt;
  end

  // A line_start in any state restarts evaluation, which also aborts a fetch in flight.
  always_comb begin
    w_state_nxt = r_state;
    w_busy      = 1'b0;
    w_cs        = 1'b0;
    case (r_state)
      IDLE: ;
      FETCH: begin
        w_busy = 1'b1;
        w_cs   = 1'b1;
        if (r_col == LAST_COL) w_state_nxt = DRAIN;
      end
      DRAIN: begin
        w_busy      = 1'b1;
        w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
    if (i_line_start) w_state_nxt = w_hit ? FETCH : IDLE;
  end

  // r_addr always presents the word for the current col_cnt while in FETCH.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_col        <= '0;
      r_row        <= '0;
      r_idx        <= '0;
      r_sx         <= '0;
      r_line_valid <= 1'b0;
      r_addr       <= '0;
    end else if (i_line_start) begin
      r_col        <= '0;
      r_row        <= w_row[RW-1:0];
      r_idx        <= i_sprite_idx;
      r_sx         <= i_sprite_x;
      r_line_valid <= 1'b0;
      if (w_hit) r_addr <= 12'({i_sprite_idx, w_row[RW-1:0], {CW{1'b0}}});
    end else begin
      case (r_state)
        FETCH: begin
          if (r_col == LAST_COL) r_col <= '0;
          else begin
            r_col  <= r_col + CW'(1);
            r_addr <= 12'({r_idx, r_row, r_col + CW'(1)});
          end
        end
        DRAIN:   r_line_valid <= 1'b1;
        default: ;
      endcase
    end
  end

`ifdef SPRITE_HFLIP_EN
  logic r_hflip;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n)          r_hflip <= 1'b0;
    else if (i_line_start) r_hflip <= i_sprite_hflip;
  end
`else
  logic w_unused_hflip;
  assign w_unused_hflip = i_sprite_hflip;
`endif

  // Read data trails the address by one cycle, so capture index lags col_cnt by one.
  assign w_cap_en = ((r_state == FETCH) && (r_col != '0)) || (r_state == DRAIN);
  assign w_cap    = (r_state == DRAIN) ? LAST_COL : r_col - CW'(1);

  always_ff @(posedge clk) begin
    if (w_cap_en) r_buf[w_cap] <= mem.mem_readdata;
  end

  assign w_col = i_pixel_x - r_sx;
  assign w_in  = r_line_valid && !w_busy && (w_col < 10'(SPRITE_W));
`ifdef SPRITE_HFLIP_EN
  assign w_ridx = r_hflip ? (LAST_COL - w_col[CW-1:0]) : w_col[CW-1:0];
`else
  assign w_ridx = w_col[CW-1:0];
`endif
  assign w_c      = r_buf[w_ridx];
  assign w_opaque = w_in && (w_c != TRANSPARENT);

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pix_rgb    <= '0;
      r_pix_opaque <= 1'b0;
    end else begin
      r_pix_opaque <= w_opaque;
      r_pix_rgb    <= w_opaque ? w_c : 16'h0000;
    end
  end

  assign o_pixel_rgb        = r_pix_rgb;
  assign o_pixel_opaque     = r_pix_opaque;
  assign o_fetch_busy       = w_busy;
  assign mem.mem_address    = r_addr;
  assign mem.mem_chipselect = w_cs;
  assign mem.mem_write      = 1'b0;
  assign mem.mem_byteenable = 2'b11;

endmodule

// File: tb/tb_vga_sprite_line_fetcher.sv
// Directed bench for vga_sprite_line_fetcher with a registered-read sprite RAM model.
module tb_vga_sprite_line_fetcher;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        line_start, sprite_en, sprite_hflip;
  logic [9:0]  line_y, sprite_x, sprite_y, pixel_x;
  logic [1:0]  sprite_idx;
  logic [15:0] pixel_rgb;
  logic        pixel_opaque, fetch_busy;
  logic [15:0] ram [4096];
  int          errors = 0;
  int          checks = 0;

  vga_sprite_line_fetcher_if mem();

  vga_sprite_line_fetcher dut (
    .clk(clk), .reset_n(reset_n),
    .i_line_start(line_start), .i_line_y(line_y), .i_sprite_en(sprite_en),
    .i_sprite_idx(sprite_idx), .i_sprite_x(sprite_x), .i_sprite_y(sprite_y),
    .i_sprite_hflip(sprite_hflip), .i_pixel_x(pixel_x),
    .o_pixel_rgb(pixel_rgb), .o_pixel_opaque(pixel_opaque), .o_fetch_busy(fetch_busy),
    .mem(mem.master)
  );

  always #5 clk = ~clk;

  always @(posedge clk) mem.mem_readdata <= ram[mem.mem_address];

  task automatic step(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic start_line(input logic [9:0] y, input logic [1:0] idx);
    line_y = y; sprite_idx = idx; line_start = 1'b1;
    step(1);
    line_start = 1'b0;
  endtask

  // Entered at T+1; leaves at T+34 with the row loaded.
  task automatic run_fetch(input logic [11:0] base);
    for (int k = 0; k < 32; k++) begin
      chk("fetch_addr", 16'(mem.mem_address), 16'(base + 12'(k)));
      chk("fetch_cs", 16'(mem.mem_chipselect), 16'd1);
      chk("fetch_busy", 16'(fetch_busy), 16'd1);
      step(1);
    end
    chk("drain_busy", 16'(fetch_busy), 16'd1);
    chk("drain_cs", 16'(mem.mem_chipselect), 16'd0);
    step(1);
    chk("done_busy", 16'(fetch_busy), 16'd0);
  endtask

  task automatic pix(input string tag, input logic [9:0] x, input logic [15:0] rgb, input logic op);
    pixel_x = x;
    step(1);
    chk({tag, "_rgb"}, pixel_rgb, rgb);
    chk({tag, "_op"}, 16'(pixel_opaque), 16'(op));
  endtask

  task automatic no_fetch(input string tag, input int n);
    int seen = 0;
    repeat (n) begin
      if (mem.mem_chipselect !== 1'b0 || fetch_busy !== 1'b0) seen++;
      step(1);
    end
    chk(tag, 16'(seen), 16'd0);
  endtask

  initial begin
    for (int i = 0; i < 4096; i++) ram[i] = 16'(i);
    ram[12'h865] = 16'hF81F;
    reset_n = 1'b0; line_start = 1'b0; sprite_en = 1'b1; sprite_hflip = 1'b0;
    line_y = '0; sprite_x = 10'd100; sprite_y = 10'd50; sprite_idx = 2'd2; pixel_x = '0;
    #3;
    chk("rst_rgb", pixel_rgb, 16'h0000);
    chk("rst_op", 16'(pixel_opaque), 16'd0);
    chk("rst_busy", 16'(fetch_busy), 16'd0);
    chk("rst_cs", 16'(mem.mem_chipselect), 16'd0);
    chk("rst_addr", 16'(mem.mem_address), 16'h0000);
    chk("tie_we", 16'(mem.mem_write), 16'd0);
    chk("tie_be", 16'(mem.mem_byteenable), 16'd3);
    step(2);
    reset_n = 1'b1;
    step(1);

    // Basic fetch of idx 2, row 3, plus transparency and edge columns
    start_line(10'd53, 2'd2);
    run_fetch(12'h860);
    pix("px100", 10'd100, 16'h0860, 1'b1);
    pix("px131", 10'd131, 16'h087F, 1'b1);
    pix("px132", 10'd132, 16'h0000, 1'b0);
    pix("px99", 10'd99, 16'h0000, 1'b0);
    pix("px104", 10'd104, 16'h0864, 1'b1);
    pix("px105", 10'd105, 16'h0000, 1'b0);
    pix("px106", 10'd106, 16'h0866, 1'b1);

    // Vertical misses above and below the sprite
    start_line(10'd49, 2'd2);
    no_fetch("miss49_nocs", 40);
    pix("miss49", 10'd100, 16'h0000, 1'b0);
    start_line(10'd82, 2'd2);
    no_fetch("miss82_nocs", 40);
    pix("miss82", 10'd110, 16'h0000, 1'b0);
    start_line(10'd81, 2'd2);
    run_fetch(12'hBE0);
    pix("row31_l", 10'd100, 16'h0BE0, 1'b1);
    pix("row31_r", 10'd131, 16'h0BFF, 1'b1);

    // Disabled sprite misses even on a matching line
    sprite_en = 1'b0;
    start_line(10'd53, 2'd2);
    no_fetch("dis_nocs", 36);
    pix("dis", 10'd100, 16'h0000, 1'b0);
    sprite_en = 1'b1;

    // Abort a fetch 10 cycles in with a new line on idx 1, row 10
    start_line(10'd53, 2'd2);
    step(9);
    chk("abort_pre", 16'(mem.mem_address), 16'h0869);
    start_line(10'd60, 2'd1);
    run_fetch(12'h540);
    pix("abort_l", 10'd100, 16'h0540, 1'b1);
    pix("abort_r", 10'd131, 16'h055F, 1'b1);

    // Reset in the middle of a fetch
    start_line(10'd53, 2'd2);
    step(14);
    chk("mid_cs", 16'(mem.mem_chipselect), 16'd1);
    reset_n = 1'b0;
    #1;
    chk("rstm_cs", 16'(mem.mem_chipselect), 16'd0);
    chk("rstm_busy", 16'(fetch_busy), 16'd0);
    chk("rstm_op", 16'(pixel_opaque), 16'd0);
    chk("rstm_addr", 16'(mem.mem_address), 16'h0000);
    step(2);
    reset_n = 1'b1;
    no_fetch("rstm_nocs", 40);
    pix("rstm_pix", 10'd100, 16'h0000, 1'b0);

    // Mirror request
    sprite_hflip = 1'b1;
    start_line(10'd53, 2'd2);
    run_fetch(12'h860);
`ifdef SPRITE_HFLIP_EN
    pix("flip_l", 10'd100, 16'h087F, 1'b1);
    pix("flip_26", 10'd105, 16'h087A, 1'b1);
    pix("flip_r", 10'd131, 16'h0860, 1'b1);
`else
    pix("noflip_l", 10'd100, 16'h0860, 1'b1);
    pix("noflip_r", 10'd131, 16'h087F, 1'b1);
`endif

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
